// File: rtl/overlay_stream_unpacker.sv
// Overlay word stream to pixel stream unpacker: a DEPTH-entry word FIFO feeds a
// holding register that emits RATIO pixels per word at up to one pixel per clock.
module overlay_stream_unpacker #(
  parameter int IN_W      = 64,
  parameter int PIX_W     = 16,
  parameter int DEPTH     = 16,
  parameter int FIRST_LSB = 1
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset,
  input  logic [IN_W-1:0]            overlay_data,
  input  logic                       overlay_sof,
  input  logic                       overlay_valid,
  output logic                       overlay_ready,
  input  logic                       flush,
  output logic [PIX_W-1:0]           pix_data,
  output logic                       pix_sof,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [15:0]                underrun_cnt
);

  localparam int RATIO = IN_W / PIX_W;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = (RATIO > 1) ? $clog2(RATIO) : 1;

  if (IN_W % PIX_W != 0) begin : g_bad_width
    $error("overlay_stream_unpacker: IN_W must be a multiple of PIX_W");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("overlay_stream_unpacker: DEPTH must be a power of two >= 2");
  end

  function automatic logic [PIX_W-1:0] lane_sel(input logic [IN_W-1:0] word,
                                                input logic [LW-1:0]   lane);
    int idx;
    idx = (FIRST_LSB != 0) ? int'(lane) : (RATIO - 1 - int'(lane));
    return word[idx*PIX_W +: PIX_W];
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // FIFO storage: {sof, word}; data only, never reset
  logic [IN_W:0]  fifo_mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    level_q, level_d;

  logic [IN_W-1:0]  hold_data_q, hold_data_d;
  logic             hold_sof_q, hold_sof_d;
  logic             hold_vld_q, hold_vld_d;
  logic [LW-1:0]    lane_q, lane_d;
  logic [PIX_W-1:0] pix_data_q, pix_data_d;
  logic             pix_sof_q, pix_sof_d;
  logic             armed_q, armed_d;
  logic [15:0]      under_q, under_d;

  logic          full, empty, wr_en, rd_en, pix_hs, last_lane;
  logic [IN_W:0] head;

  assign full          = (level_q == (AW+1)'(DEPTH));
  assign empty         = (level_q == '0);
  assign overlay_ready = !full && !reset_reset && !flush;
  assign wr_en         = overlay_valid && overlay_ready;
  assign pix_hs        = hold_vld_q && pix_ready;
  assign last_lane     = (lane_q == LW'(RATIO - 1));
  // Pop when the holding register is free now or is freed by this handshake
  assign rd_en         = !empty && !flush && (!hold_vld_q || (pix_hs && last_lane));
  assign head          = fifo_mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d    = wr_ptr_q + AW'(wr_en);
    rd_ptr_d    = rd_ptr_q + AW'(rd_en);
    level_d     = level_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    hold_data_d = hold_data_q;
    hold_sof_d  = hold_sof_q;
    hold_vld_d  = hold_vld_q;
    lane_d      = lane_q;
    armed_d     = armed_q | (pix_hs && pix_sof_q);
    under_d     = under_q;

    if (rd_en) begin
      hold_data_d = head[IN_W-1:0];
      hold_sof_d  = head[IN_W];
      hold_vld_d  = 1'b1;
      lane_d      = '0;
    end else if (pix_hs) begin
      if (last_lane) begin
        hold_vld_d = 1'b0;
        lane_d     = '0;
      end else begin
        lane_d = lane_q + LW'(1);
      end
    end

    if (armed_q && pix_ready && !hold_vld_q) begin
      under_d = sat_inc(under_q);
    end

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      hold_vld_d = 1'b0;
      hold_sof_d = 1'b0;
      lane_d     = '0;
      armed_d    = 1'b0;
      under_d    = '0;
    end

    pix_data_d = hold_vld_d ? lane_sel(hold_data_d, lane_d) : '0;
    pix_sof_d  = hold_vld_d && hold_sof_d && (lane_d == '0);
  end

  always_ff @(posedge clk_clk) begin
    if (wr_en) begin
      fifo_mem_q[wr_ptr_q] <= {overlay_sof, overlay_data};
    end
    hold_data_q <= hold_data_d;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      hold_sof_q <= 1'b0;
      hold_vld_q <= 1'b0;
      lane_q     <= '0;
      pix_data_q <= '0;
      pix_sof_q  <= 1'b0;
      armed_q    <= 1'b0;
      under_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      hold_sof_q <= hold_sof_d;
      hold_vld_q <= hold_vld_d;
      lane_q     <= lane_d;
      pix_data_q <= pix_data_d;
      pix_sof_q  <= pix_sof_d;
      armed_q    <= armed_d;
      under_q    <= under_d;
    end
  end

  assign pix_data     = pix_data_q;
  assign pix_sof      = pix_sof_q;
  assign pix_valid    = hold_vld_q;
  assign fifo_level   = level_q;
  assign underrun_cnt = under_q;

endmodule
